note_classifier: RTL and testbench
==================================

# note_classifier

Measures the period of the conditioned audio square wave from the input comparator and classifies it as one of the seven natural notes C4–B4. It also reports whether the note is in tune, flat, or sharp. It sits directly upstream of the seven-segment digit decoder: its `digit` output (0..6 = C..B, 7 = no note) drives the decoder's 3-bit digit input. Fixed for a 100 MHz `clk`.

## Interface
- `STABLE_N`, default 3: consecutive same-note periods required before `digit` updates (1..7).
- `CNT_W`, default 20: period counter width; must hold `E[0]` = 393420.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `sig_in`  in  1  asynchronous comparator output of the audio signal.
- `digit`  out  3  note index 0..6 = C,D,E,F,G,A,B; 7 = no note. Reset 7.
- `tune`  out  2  00 in tune, 01 sharp, 10 flat; 11 never driven. Reset 00.
- `note_valid`  out  1  high while `digit` holds a qualified note. Reset 0.

## Operation
- **Input path:** `sig_in` passes through a 2-FF synchronizer, then a rising-edge detect producing a 1-cycle `edge` pulse.
- **Period counter:**
  - Cleared to 1 on `edge`, increments every cycle, saturates at `E[0]`.
  - The first `edge` after reset or timeout only arms the counter; no period is produced.
  - Each later `edge` latches `period` = counter value and enters CLASSIFY.
- **FSM states:**
  - IDLE → MEASURE on first `edge`.
  - MEASURE → CLASSIFY on `edge`.
  - CLASSIFY → REPORT when a match is found or the index is exhausted.
  - REPORT → MEASURE after one cycle.
  - Timeout from MEASURE → IDLE.
- **CLASSIFY:** scans index i = 0..6, one per cycle. Note i matches when `E[i+1] <= period < E[i]`. If no index matches, the period is out of range.
- **Stability (in REPORT):**
  - Out of range: `cand` := 7, `match_cnt` := 0; outputs hold.
  - Match n with n == `cand`: `match_cnt` increments, saturating at `STABLE_N`.
  - Match n with n != `cand`: `cand` := n, `match_cnt` := 1.
  - When `match_cnt` == `STABLE_N` after the update: `digit` := n, `note_valid` := 1, `tune` computed from this period.
- **Tune:** band = `CENTER[n]` >> 7, unsigned, `CNT_W` bits.
  - `period` > `CENTER[n]` + band → 10 (flat).
  - `period` < `CENTER[n]` − band → 01 (sharp).
  - Otherwise 00.
- **Timeout:** counter reaches `E[0]` in MEASURE → `digit` := 7, `note_valid` := 0, `tune` := 00, `cand` := 7, `match_cnt` := 0, go to IDLE.
- **Edge during CLASSIFY/REPORT:** abandons the current result. It is treated as out of range, and the counter restarts at 1 in MEASURE.
- **`rst` mid-operation:** all state returns to reset values on the next `clk`; the synchronizer is cleared to 0.

## Timing
- Rising `sig_in` → `edge` pulse: 3 cycles (2 sync + 1 detect).
- `edge` → outputs updated: at most 9 cycles (latch 1, CLASSIFY up to 7, REPORT 1).
- Total: at most 12 cycles from the `sig_in` edge that closes the qualifying period.
- Outputs are registered and change only in REPORT, on timeout, or on reset.
- Measured period equals the exact number of `clk` cycles between consecutive detected edges.

## Structure
- Package `note_pkg` holds:
  - `E[0:7]` = 393420, 360770, 321410, 294730, 270270, 240790, 214520, 196720.
  - `CENTER[0:6]` = 382226, 340530, 303372, 286344, 255102, 227273, 202478.
  - `NO_NOTE` = 3'd7.
  - Tune encodings `TUNE_OK`/`TUNE_SHARP`/`TUNE_FLAT`.
  - FSM state typedef.
- Sub-module `sig_edge_detect`: 2-FF synchronizer plus rising-edge pulse, with `clk`/`rst`.

## Test plan
- Reset asserted 5 cycles, `sig_in` toggling → `digit`=7, `note_valid`=0, `tune`=00 throughout and 1 cycle after release.
- Square wave, period 227273 cycles, 4 rising edges → `digit`=5, `note_valid`=1, `tune`=00 within 12 cycles of the 4th edge; unchanged after the 3rd edge.
- Periods of 230000 ×3 → `digit`=5, `tune`=10. Then 224000 ×3 → `tune`=01, with the first update after the first 224000 period.
- Qualified `digit`=5, then periods alternating 255102/227273 → `digit` stays 5. Then 255102 ×3 → `digit`=4.
- Qualified note, then `sig_in` held low for 393420 cycles → `digit`=7, `note_valid`=0, `tune`=00. The next edge produces no update.
- Periods of 150000 ×4 (too short) → no output change. `rst` pulsed mid-period → counter rearms, and 4 edges at 382226 give `digit`=0.

Source files
------------

// File: rtl/note_classifier_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// note_pkg
//   Period bounds, note centres, tune codes and FSM encoding for note_classifier.
//   Revision: 1.0
// ============================================================================
package note_pkg;

    // Period bounds in 100 MHz cycles; note i owns [E[i+1], E[i]).
    localparam int unsigned E [0:7] = '{
        393420, 360770, 321410, 294730, 270270, 240790, 214520, 196720
    };

    localparam int unsigned CENTER [0:6] = '{
        382226, 340530, 303372, 286344, 255102, 227273, 202478
    };

    localparam logic [2:0] NO_NOTE = 3'd7;

    localparam logic [1:0] TUNE_OK    = 2'b00;
    localparam logic [1:0] TUNE_SHARP = 2'b01;
    localparam logic [1:0] TUNE_FLAT  = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_MEASURE  = 2'd1;
    localparam state_t ST_CLASSIFY = 2'd2;
    localparam state_t ST_REPORT   = 2'd3;

    // Centre period of note n; NO_NOTE maps to 0 so the lookup stays in range.
    function automatic int unsigned center_of(input logic [2:0] n);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 7; i++) begin
            if (n == 3'(i)) begin
                c = CENTER[i];
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_classifier_sig_edge_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sig_edge_detect
//   Two-flop synchronizer for the comparator output plus a registered
//   one-cycle rising-edge pulse.
//   Revision: 1.0
// ============================================================================
module sig_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            rise   <= 1'b0;
        end else begin
            r_meta <= sig_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
            rise   <= r_sync & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// note_classifier
//   Measures the period of the conditioned audio square wave, classifies it
//   as one of C4..B4 and reports tuning once the note has been stable.
//   Revision: 1.0
// ============================================================================
module note_classifier
    import note_pkg::*;
#(
    parameter int STABLE_N = 3,
    parameter int CNT_W    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    output logic [2:0] digit,
    output logic [1:0] tune,
    output logic       note_valid
);

    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(E[0]);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [2:0]       c_stable   = 3'(STABLE_N);
    localparam logic [2:0]       c_last_idx = 3'd6;

    logic             w_rise;
    logic [CNT_W-1:0] w_hi;
    logic [CNT_W-1:0] w_lo;
    logic             w_hit;
    logic [CNT_W-1:0] w_center;
    logic [CNT_W-1:0] w_band;
    logic [1:0]       w_tune;
    logic [2:0]       w_match_next;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [2:0]       r_idx;
    logic [2:0]       r_note;
    logic             r_in_range;
    logic [2:0]       r_cand;
    logic [2:0]       r_match_cnt;

    sig_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (w_rise)
    );

    // Scan window for the current index plus tune/stability of the last result.
    always_comb begin
        w_hi     = CNT_W'(E[r_idx]);
        w_lo     = CNT_W'(E[r_idx + 3'd1]);
        w_hit    = (r_period >= w_lo) && (r_period < w_hi);

        w_center = CNT_W'(center_of(r_note));
        w_band   = w_center >> 7;
        if (r_period > (w_center + w_band)) begin
            w_tune = TUNE_FLAT;
        end else if (r_period < (w_center - w_band)) begin
            w_tune = TUNE_SHARP;
        end else begin
            w_tune = TUNE_OK;
        end

        if (r_note == r_cand) begin
            w_match_next = (r_match_cnt >= c_stable) ? c_stable : (r_match_cnt + 3'd1);
        end else begin
            w_match_next = 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_period    <= '0;
            r_idx       <= 3'd0;
            r_note      <= NO_NOTE;
            r_in_range  <= 1'b0;
            r_cand      <= NO_NOTE;
            r_match_cnt <= 3'd0;
            digit       <= NO_NOTE;
            tune        <= TUNE_OK;
            note_valid  <= 1'b0;
        end else begin
            // Free-running period counter, restarted by every detected edge.
            if (w_rise) begin
                r_cnt <= c_one;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_one;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    if (w_rise) begin
                        r_period <= r_cnt;
                        r_idx    <= 3'd0;
                        r_state  <= ST_CLASSIFY;
                    end else if (r_cnt == c_cnt_max) begin
                        digit       <= NO_NOTE;
                        tune        <= TUNE_OK;
                        note_valid  <= 1'b0;
                        r_cand      <= NO_NOTE;
                        r_match_cnt <= 3'd0;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_CLASSIFY: begin
                    if (w_rise) begin
                        r_cand      <= NO_NOTE;
                        r_match_cnt <= 3'd0;
                        r_state     <= ST_MEASURE;
                    end else if (w_hit) begin
                        r_note     <= r_idx;
                        r_in_range <= 1'b1;
                        r_state    <= ST_REPORT;
                    end else if (r_idx == c_last_idx) begin
                        r_in_range <= 1'b0;
                        r_state    <= ST_REPORT;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end

                ST_REPORT: begin
                    r_state <= ST_MEASURE;
                    if (w_rise || !r_in_range) begin
                        r_cand      <= NO_NOTE;
                        r_match_cnt <= 3'd0;
                    end else begin
                        r_cand      <= r_note;
                        r_match_cnt <= w_match_next;
                        if (w_match_next == c_stable) begin
                            digit      <= r_note;
                            tune       <= w_tune;
                            note_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_note_classifier
//   Directed vector table, glitch corner case and randomized periods checked
//   against an edge-level reference model.
//   Revision: 1.0
// ============================================================================
module tb_note_classifier;

    localparam int STABLE_N = 3;
    localparam int CNT_W    = 20;

    localparam int T_E [0:7] = '{393420, 360770, 321410, 294730, 270270, 240790, 214520, 196720};
    localparam int T_C [0:6] = '{382226, 340530, 303372, 286344, 255102, 227273, 202478};

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_in;
    logic [2:0] digit;
    logic [1:0] tune;
    logic       note_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state, advanced once per rising edge of sig_in.
    bit         m_armed;
    int         m_cand;
    int         m_cnt;
    logic [2:0] m_digit;
    logic [1:0] m_tune;
    logic       m_valid;

    note_classifier #(
        .STABLE_N (STABLE_N),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .digit      (digit),
        .tune       (tune),
        .note_valid (note_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         gap;
        bit         rst_before;
        logic [2:0] digit;
        logic [1:0] tune;
        logic       valid;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name,
                         input logic [2:0] d, input logic [1:0] t, input logic v,
                         input logic [2:0] ed, input logic [1:0] et, input logic ev);
        checks++;
        if ({d, t, v} !== {ed, et, ev}) begin
            failures++;
            $display("FAIL %s: got digit=%0d tune=%b valid=%b, want digit=%0d tune=%b valid=%b",
                     name, d, t, v, ed, et, ev);
        end
    endtask

    // Rising edge now, outputs sampled 12 cycles later, next rising edge after gap cycles.
    task automatic pulse(input int gap, output logic [2:0] d, output logic [1:0] t, output logic v);
        sig_in = 1'b1;
        repeat (12) @(negedge clk);
        d = digit;
        t = tune;
        v = note_valid;
        repeat (gap / 2 - 12) @(negedge clk);
        sig_in = 1'b0;
        repeat (gap - gap / 2) @(negedge clk);
    endtask

    function automatic int classify(input int p);
        int n;
        n = 7;
        for (int i = 0; i < 7; i++) begin
            if (p >= T_E[i+1] && p < T_E[i]) n = i;
        end
        return n;
    endfunction

    function automatic void model_reset();
        m_armed = 1'b0;
        m_cand  = 7;
        m_cnt   = 0;
        m_digit = 3'd7;
        m_tune  = 2'b00;
        m_valid = 1'b0;
    endfunction

    function automatic void model_edge(input int period);
        int n;
        int band;
        if (!m_armed) begin
            m_armed = 1'b1;
            return;
        end
        n = classify(period);
        if (n == 7) begin
            m_cand = 7;
            m_cnt  = 0;
            return;
        end
        if (n == m_cand) begin
            m_cnt = (m_cnt < STABLE_N) ? m_cnt + 1 : STABLE_N;
        end else begin
            m_cand = n;
            m_cnt  = 1;
        end
        if (m_cnt == STABLE_N) begin
            band    = T_C[n] / 128;
            m_digit = 3'(n);
            m_valid = 1'b1;
            if (period > T_C[n] + band)      m_tune = 2'b10;
            else if (period < T_C[n] - band) m_tune = 2'b01;
            else                             m_tune = 2'b00;
        end
    endfunction

    initial begin
        logic [2:0] d;
        logic [1:0] t;
        logic       v;
        int         prev;
        int         g;
        int         note;

        vecs[0]  = '{227273, 1'b0, 3'd7, 2'b00, 1'b0};
        vecs[1]  = '{227273, 1'b0, 3'd7, 2'b00, 1'b0};
        vecs[2]  = '{227273, 1'b0, 3'd7, 2'b00, 1'b0};
        vecs[3]  = '{230000, 1'b0, 3'd5, 2'b00, 1'b1};
        vecs[4]  = '{230000, 1'b0, 3'd5, 2'b10, 1'b1};
        vecs[5]  = '{230000, 1'b0, 3'd5, 2'b10, 1'b1};
        vecs[6]  = '{224000, 1'b0, 3'd5, 2'b10, 1'b1};
        vecs[7]  = '{224000, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[8]  = '{224000, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[9]  = '{255102, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[10] = '{227273, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[11] = '{255102, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[12] = '{227273, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[13] = '{255102, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[14] = '{255102, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[15] = '{255102, 1'b0, 3'd5, 2'b01, 1'b1};
        vecs[16] = '{150000, 1'b0, 3'd4, 2'b00, 1'b1};
        vecs[17] = '{150000, 1'b0, 3'd4, 2'b00, 1'b1};
        vecs[18] = '{150000, 1'b0, 3'd4, 2'b00, 1'b1};
        vecs[19] = '{150000, 1'b0, 3'd4, 2'b00, 1'b1};
        vecs[20] = '{400000, 1'b0, 3'd4, 2'b00, 1'b1};
        vecs[21] = '{100000, 1'b0, 3'd7, 2'b00, 1'b0};
        vecs[22] = '{382226, 1'b1, 3'd7, 2'b00, 1'b0};
        vecs[23] = '{382226, 1'b0, 3'd7, 2'b00, 1'b0};
        vecs[24] = '{382226, 1'b0, 3'd7, 2'b00, 1'b0};
        vecs[25] = '{205000, 1'b0, 3'd0, 2'b00, 1'b1};

        // Reset held while the input toggles.
        rst    = 1'b1;
        sig_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sig_in = ~sig_in;
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), digit, tune, note_valid, 3'd7, 2'b00, 1'b0);
        end
        sig_in = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("reset_release", digit, tune, note_valid, 3'd7, 2'b00, 1'b0);

        for (int i = 0; i < 26; i++) begin
            if (vecs[i].rst_before) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid_period", digit, tune, note_valid, 3'd7, 2'b00, 1'b0);
            end
            pulse(vecs[i].gap, d, t, v);
            check($sformatf("vec%0d", i), d, t, v, vecs[i].digit, vecs[i].tune, vecs[i].valid);
        end

        // Glitch edge 3 cycles after the edge closing a B4 period: that result is dropped.
        sig_in = 1'b1;
        @(negedge clk);
        sig_in = 1'b0;
        repeat (2) @(negedge clk);
        pulse(205000, d, t, v);
        check("glitch_abandon", d, t, v, 3'd0, 2'b00, 1'b1);
        pulse(205000, d, t, v);
        check("glitch_after1", d, t, v, 3'd0, 2'b00, 1'b1);
        pulse(205000, d, t, v);
        check("glitch_after2", d, t, v, 3'd0, 2'b00, 1'b1);
        pulse(1000, d, t, v);
        check("glitch_after3", d, t, v, 3'd6, 2'b10, 1'b1);

        // Randomized periods against the reference model.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rand_reset", digit, tune, note_valid, 3'd7, 2'b00, 1'b0);
        model_reset();
        prev = 0;
        note = 0;
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) note = int'($urandom_range(0, 7));
            if (note == 7) g = 100000 + int'($urandom_range(0, 90000));
            else           g = T_E[note+1] + int'($urandom_range(0, T_E[note] - T_E[note+1] - 1));
            pulse(g, d, t, v);
            model_edge(prev);
            check($sformatf("rand%0d_p%0d", k, prev), d, t, v, m_digit, m_tune, m_valid);
            prev = g;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
